transport_tx_scheduler: RTL and testbench
=========================================

// Module: transport_tx_scheduler
// PURPOSE
// Schedules the shared transport send path between the control-message and audio channels.
// Accepts 16-bit control words and a stream of 16-bit audio samples. Builds fixed-length
// byte packets and arbitrates with control-first priority plus an audio anti-starvation guard.
// Streams the packet bytes to the link layer over a valid/ready byte interface.
// PARAMETERS
// PKT_BYTES      16  bytes per packet, even, >=4; header+dest+payload; SPP=(PKT_BYTES-2)/2 samples/pkt
// AUD_DEPTH      16  audio sample FIFO depth, power of 2, >= SPP
// MAX_CTRL_RUN   3   max consecutive ctrl packets while an audio packet is eligible
// PORTS
// clk        in   1   clock
// reset      in   1   synchronous, active-high reset
// phone_num  in   8   destination number; sampled when a packet is granted
// ctrl_valid in   1   control word offered
// ctrl_data  in   16  control word
// ctrl_ready out  1   1 = ctrl holding register empty; transfer on ctrl_valid&ctrl_ready
// aud_valid  in   1   audio sample offered
// aud_data   in   16  audio sample
// aud_ready  out  1   1 = FIFO count < AUD_DEPTH
// out_valid  out  1   byte valid to link
// out_data   out  8   packet byte
// out_sop    out  1   marks header byte
// out_eop    out  1   marks last byte (index PKT_BYTES-1)
// out_ready  in   1   link accepts byte on out_valid&out_ready
// busy       out  1   1 in any state other than IDLE
// aud_level  out  $clog2(AUD_DEPTH)+1  FIFO occupancy
// aud_drop   out  1   1-cycle pulse: aud_valid while !aud_ready (sample discarded)
// BEHAVIOUR
// - Reset: all outputs 0 except ctrl_ready=1, aud_ready=1; FIFO and holding reg cleared; run count 0.
// - Reset mid-packet aborts immediately: no eop, partial packet abandoned, queued data lost.
// - Holding reg: loads on ctrl handshake; frees when its last payload byte is accepted.
// - FIFO: push on aud_valid&aud_ready; pop when the low byte of a sample is accepted.
// - Simultaneous push+pop leaves the count unchanged. At full, pop does not enable a same-cycle push.
// - FSM IDLE -> HDR -> DEST -> PAYLOAD -> IDLE. Only IDLE arbitrates.
// - Audio eligible when aud_level >= SPP.
// - IDLE grant: if ctrl held and (audio not eligible or run<MAX_CTRL_RUN), grant CTRL and run++.
//   Otherwise, if audio eligible, grant AUDIO and run=0.
//   A CTRL grant made with audio not eligible also resets run to 0.
// - On grant: latch type and phone_num; go HDR next cycle. 1-cycle arbitration latency, no same-cycle bypass.
// - HDR: out_data = 8'h40 for CTRL, 8'h80 for AUDIO; out_sop=1. DEST: out_data = latched phone_num.
// - PAYLOAD CTRL: ctrl_data[15:8], ctrl_data[7:0], then 8'h00 pad to PKT_BYTES.
// - PAYLOAD AUDIO: SPP samples in FIFO order, each sent high byte first.
// - out_valid stays 1 from HDR through the eop byte. Each state advances only on out_ready.
// - out_data/sop/eop are held stable while out_valid & !out_ready.
// - Byte counter runs 0..PKT_BYTES-1. eop at count PKT_BYTES-1.
//   On eop acceptance: return to IDLE with out_valid=0; the next packet's HDR comes >=1 cycle later.
// - Input handshakes run independently of FSM state, including during backpressure.
// TESTING
// 1. Reset, ctrl 16'hBEEF, phone_num 8'h07, out_ready=1 -> 40 07 BE EF then 12x00.
//    sop on byte 0, eop on byte 15; ctrl_ready returns 1 after EF is accepted.
// 2. Push 7 samples 16'h0102..16'h0D0E, out_ready=1 -> 80 dd 01 02 .. 0D 0E; aud_level 7->0.
// 3. Ctrl offered every IDLE, audio eligible, MAX_CTRL_RUN=3 -> packet types C,C,C,A,C,C,C,A.
// 4. Push 17 samples with no drain -> aud_ready=0 after the 16th; aud_drop pulses once; level=16.
// 5. Random out_ready throttling (~50%) on audio pkt -> bytes identical to case 2; out_data stable when stalled.
// 6. Assert reset at byte 5 -> next cycle out_valid=0, busy=0, aud_level=0, ctrl_ready=1, no eop seen.

Source files
------------

// File: rtl/transport_tx_scheduler.sv
// transport_tx_scheduler
// Shares one byte-wide link between control words and audio samples.
// Packet layout: header byte, destination byte, then payload bytes.
// Control packets win arbitration unless audio is ready and control has
// already sent MAX_CTRL_RUN packets in a row. This keeps audio from starving.
module transport_tx_scheduler #(
    parameter  int PKT_BYTES    = 16,
    parameter  int AUD_DEPTH    = 16,
    parameter  int MAX_CTRL_RUN = 3,
    localparam int SPP          = (PKT_BYTES - 2) / 2,
    localparam int AW           = $clog2(AUD_DEPTH),
    localparam int LW           = AW + 1,
    localparam int CW           = $clog2(PKT_BYTES),
    localparam int RW           = $clog2(MAX_CTRL_RUN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    phone_num,
    input  logic          ctrl_valid,
    input  logic [15:0]   ctrl_data,
    output logic          ctrl_ready,
    input  logic          aud_valid,
    input  logic [15:0]   aud_data,
    output logic          aud_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_sop,
    output logic          out_eop,
    input  logic          out_ready,
    output logic          busy,
    output logic [LW-1:0] aud_level,
    output logic          aud_drop
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DEST, S_PAYLOAD} state_t;

    localparam logic [LW-1:0] SPP_L    = LW'(SPP);
    localparam logic [LW-1:0] DEPTH_L  = LW'(AUD_DEPTH);
    localparam logic [CW-1:0] LAST_C   = CW'(PKT_BYTES - 1);
    localparam logic [CW-1:0] CLO_C    = CW'(3);
    localparam logic [CW-1:0] CHI_C    = CW'(2);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_CTRL_RUN);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          is_aud_q;
    logic [7:0]    phone_q;
    logic [RW-1:0] run_q;

    logic          hold_vld_q;
    logic [15:0]   hold_q;

    logic [15:0]   mem_q [AUD_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;

    logic          accept, push, pop, ctrl_load, ctrl_free, aud_elig;
    logic [15:0]   aud_head;

    // Link-side status comes straight from the state registers.
    assign out_valid  = (state_q != S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_sop    = (state_q == S_HDR);
    assign out_eop    = (state_q == S_PAYLOAD) && (cnt_q == LAST_C);
    assign accept     = out_valid && out_ready;

    assign ctrl_ready = !hold_vld_q;
    assign ctrl_load  = ctrl_valid && ctrl_ready;
    // The holding register frees after its low byte goes out. Pad bytes do not need it.
    assign ctrl_free  = accept && (state_q == S_PAYLOAD) && !is_aud_q && (cnt_q == CLO_C);

    // Readiness uses the registered count. A pop at full cannot make room in the same cycle.
    assign aud_ready  = (level_q < DEPTH_L);
    assign aud_drop   = aud_valid && !aud_ready;
    assign push       = aud_valid && aud_ready;
    // Payload starts at an even index. An odd index is the low byte, which ends the sample.
    assign pop        = accept && (state_q == S_PAYLOAD) && is_aud_q && cnt_q[0];
    assign aud_level  = level_q;
    assign aud_elig   = (level_q >= SPP_L);
    assign aud_head   = mem_q[rptr_q];

    // Byte mux. Every source here only changes after a byte is accepted, so the mux holds steady under backpressure.
    always_comb begin
        out_data = 8'h00;
        case (state_q)
            S_HDR:     out_data = is_aud_q ? 8'h80 : 8'h40;
            S_DEST:    out_data = phone_q;
            S_PAYLOAD: begin
                if (is_aud_q)
                    out_data = cnt_q[0] ? aud_head[7:0] : aud_head[15:8];
                else if (cnt_q == CHI_C)
                    out_data = hold_q[15:8];
                else if (cnt_q == CLO_C)
                    out_data = hold_q[7:0];
                else
                    out_data = 8'h00;
            end
            default:   out_data = 8'h00;
        endcase
    end

    // Control holding register: one word deep.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
            hold_q     <= 16'h0000;
        end else if (ctrl_load) begin
            hold_vld_q <= 1'b1;
            hold_q     <= ctrl_data;
        end else if (ctrl_free) begin
            hold_vld_q <= 1'b0;
        end
    end

    // Audio FIFO storage. Clearing the pointers empties the FIFO, so the array has no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= aud_data;
    end

    // Audio FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Packet FSM. Arbitration happens only in IDLE. The granted header appears the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_aud_q <= 1'b0;
            phone_q  <= 8'h00;
            run_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (hold_vld_q && (!aud_elig || (run_q < RUN_MAX))) begin
                        state_q  <= S_HDR;
                        is_aud_q <= 1'b0;
                        phone_q  <= phone_num;
                        // The run count only matters while audio is waiting.
                        run_q    <= aud_elig ? run_q + RW'(1) : '0;
                    end else if (aud_elig) begin
                        state_q  <= S_HDR;
                        is_aud_q <= 1'b1;
                        phone_q  <= phone_num;
                        run_q    <= '0;
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        state_q <= S_DEST;
                        cnt_q   <= CW'(1);
                    end
                end
                S_DEST: begin
                    if (out_ready) begin
                        state_q <= S_PAYLOAD;
                        cnt_q   <= CW'(2);
                    end
                end
                S_PAYLOAD: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_C) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transport_tx_scheduler.sv
// Bench for transport_tx_scheduler.
// Whole-packet vectors are driven from a table. Hand sequences cover the
// arbitration pattern, FIFO overflow and reset in the middle of a packet.
module tb_transport_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  phone_num;
    logic        ctrl_valid;
    logic [15:0] ctrl_data;
    logic        ctrl_ready;
    logic        aud_valid;
    logic [15:0] aud_data;
    logic        aud_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
    logic        busy;
    logic [4:0]  aud_level;
    logic        aud_drop;

    int n_vec = 0;
    int n_err = 0;

    transport_tx_scheduler #(.PKT_BYTES(16), .AUD_DEPTH(16), .MAX_CTRL_RUN(3)) dut (
        .clk(clk), .reset(reset), .phone_num(phone_num),
        .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data), .ctrl_ready(ctrl_ready),
        .aud_valid(aud_valid), .aud_data(aud_data), .aud_ready(aud_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready), .busy(busy),
        .aud_level(aud_level), .aud_drop(aud_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_aud;
        logic [15:0]  cword;
        logic [7:0]   base;
        logic [7:0]   ph;
        bit           thr;
        logic [127:0] exp_bytes;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; ctrl_valid = 1'b0; aud_valid = 1'b0; out_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic push_samples(input logic [7:0] b, input int n);
        logic [7:0] hi;
        for (int k = 0; k < n; k++) begin
            hi = b + 8'(2 * k);
            aud_valid = 1'b1;
            aud_data  = {hi, hi + 8'd1};
            tick;
        end
        aud_valid = 1'b0;
    endtask

    task automatic send_ctrl(input logic [15:0] w);
        ctrl_valid = 1'b1;
        ctrl_data  = w;
        tick;
        ctrl_valid = 1'b0;
    endtask

    // Collects one 16-byte packet. Also tracks sop/eop placement, stability while stalled and ctrl_ready timing.
    task automatic collect(input bit thr, input bit is_ctrl, output logic [127:0] got,
                           output int bad_sop, output int bad_eop, output int bad_stab,
                           output int bad_cr, output bit timeout);
        int n = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] sd = 8'h00;
        got = '0; bad_sop = 0; bad_eop = 0; bad_stab = 0; bad_cr = 0;
        while (n < 16 && cyc < 400) begin
            out_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (is_ctrl && (ctrl_ready !== (n >= 4))) bad_cr++;
            if (out_valid) begin
                if (stalled && out_data !== sd) bad_stab++;
                if (out_sop !== (n == 0)) bad_sop++;
                if (out_eop !== (n == 15)) bad_eop++;
                if (out_ready) begin
                    got[127 - 8 * n -: 8] = out_data;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = out_data;
                end
            end
            tick;
            cyc++;
        end
        timeout = (n < 16);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [127:0] got;
        logic [7:0]   types[9];
        logic [7:0]   exp_types[9];
        int bs, be, bst, bcr, drops, np, cyc, n;
        bit to, eop_seen;

        vt[0] = '{1'b0, 16'hBEEF, 8'h00, 8'h07, 1'b0, 128'h4007BEEF_00000000_00000000_00000000};
        vt[1] = '{1'b1, 16'h0000, 8'h01, 8'hDD, 1'b0, 128'h80DD0102_03040506_0708090A_0B0C0D0E};
        vt[2] = '{1'b1, 16'h0000, 8'h01, 8'hDD, 1'b1, 128'h80DD0102_03040506_0708090A_0B0C0D0E};
        vt[3] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 128'h40A51234_00000000_00000000_00000000};
        vt[4] = '{1'b1, 16'h0000, 8'hF0, 8'h3C, 1'b1, 128'h803CF0F1_F2F3F4F5_F6F7F8F9_FAFBFCFD};

        reset = 1'b1; phone_num = 8'h00; ctrl_valid = 1'b0; ctrl_data = 16'h0;
        aud_valid = 1'b0; aud_data = 16'h0; out_ready = 1'b0;
        do_reset;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl_ready", ctrl_ready, 1);
        check("rst_aud_ready", aud_ready, 1);
        check("rst_aud_level", aud_level, 0);
        check("rst_aud_drop", aud_drop, 0);

        // Table-driven packets
        for (int i = 0; i < 5; i++) begin
            phone_num = vt[i].ph;
            if (vt[i].is_aud) begin
                push_samples(vt[i].base, 7);
                check($sformatf("v%0d_level_before", i), aud_level, 7);
            end else begin
                send_ctrl(vt[i].cword);
                check($sformatf("v%0d_ctrl_ready_busy", i), ctrl_ready, 0);
            end
            collect(vt[i].thr, !vt[i].is_aud, got, bs, be, bst, bcr, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_bytes", i), got, vt[i].exp_bytes);
            check($sformatf("v%0d_sop", i), bs, 0);
            check($sformatf("v%0d_eop", i), be, 0);
            check($sformatf("v%0d_stable", i), bst, 0);
            check($sformatf("v%0d_idle_gap", i), out_valid, 0);
            if (vt[i].is_aud) check($sformatf("v%0d_level_after", i), aud_level, 0);
            else              check($sformatf("v%0d_ctrl_ready", i), bcr, 0);
            tick;
        end

        // Arbitration: a ctrl packet stalls while the FIFO fills. After that, the order is C,C,C,A repeated.
        do_reset;
        phone_num = 8'h11;
        send_ctrl(16'hC0C0);
        push_samples(8'h20, 16);
        check("arb_level_full", aud_level, 16);
        ctrl_valid = 1'b1; ctrl_data = 16'hA1A1; out_ready = 1'b1;
        exp_types = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h80, 8'h40, 8'h40, 8'h40, 8'h80};
        np = 0; cyc = 0;
        while (np < 9 && cyc < 400) begin
            if (out_valid && out_sop) begin
                types[np] = out_data;
                np++;
            end
            tick;
            cyc++;
        end
        ctrl_valid = 1'b0;
        check("arb_pkt_count", np, 9);
        for (int p = 0; p < 9; p++)
            if (p < np) check($sformatf("arb_type%0d", p), types[p], exp_types[p]);

        // Overflow: with the link stalled, 17 pushes fill the FIFO and the 17th sample is dropped.
        do_reset;
        phone_num = 8'h99;
        drops = 0;
        for (int k = 0; k < 17; k++) begin
            aud_valid = 1'b1;
            aud_data  = {8'(8'h40 + 8'(2 * k)), 8'(8'h41 + 8'(2 * k))};
            #1;
            if (aud_drop) drops++;
            if (k == 16) check("ovf_ready_after16", aud_ready, 0);
            tick;
        end
        aud_valid = 1'b0;
        check("ovf_drop_count", drops, 1);
        check("ovf_level", aud_level, 16);
        collect(1'b0, 1'b0, got, bs, be, bst, bcr, to);
        check("ovf_drain_bytes", got, 128'h80994041_42434445_46474849_4A4B4C4D);
        check("ovf_level_after", aud_level, 9);

        // Reset while byte 5 is on the link
        do_reset;
        phone_num = 8'h07;
        push_samples(8'h50, 3);
        send_ctrl(16'hBEEF);
        ctrl_valid = 1'b1; ctrl_data = 16'h5555;
        out_ready = 1'b1;
        n = 0; cyc = 0; eop_seen = 1'b0;
        while (cyc < 100) begin
            if (out_valid && n == 5) break;
            if (out_valid && out_eop) eop_seen = 1'b1;
            if (out_valid) n++;
            tick;
            cyc++;
        end
        check("mid_reach_byte5", n, 5);
        check("mid_byte5_data", out_data, 8'h00);
        reset = 1'b1; ctrl_valid = 1'b0;
        tick;
        check("mid_out_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_level", aud_level, 0);
        check("mid_ctrl_ready", ctrl_ready, 1);
        check("mid_no_eop", {eop_seen, out_eop}, 0);
        reset = 1'b0;
        tick;
        check("mid_stays_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
